// File: rtl/cla_adder_pipelined_pkg.sv
// Shared constants, types and the 4-bit carry-lookahead function for the
// pipelined CLA adder/subtractor.
package cla_pkg;

    localparam int unsigned GROUP_W = 4;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    typedef struct packed {
        logic [GROUP_W:0] c;
        logic             pg;
        logic             gg;
    } look_t;

    // Full lookahead over one 4-bit group: carries c[0..4], group propagate/generate
    function automatic look_t group_lookahead(input logic [GROUP_W-1:0] p,
                                              input logic [GROUP_W-1:0] g,
                                              input logic               c);
        look_t r;
        r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r.pg   = &p;
        r.c[0] = c;
        r.c[1] = g[0] | (p[0] & c);
        r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        r.c[4] = r.gg | (r.pg & c);
        return r;
    endfunction

endpackage

// File: rtl/cla_adder_pipelined_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
interface cla_adder_pipelined_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_adder_pipelined_group4.sv
// 4-bit carry-lookahead slice: sum bits plus group propagate/generate.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               c,
    output logic [GROUP_W-1:0] s,
    output logic               pg,
    output logic               gg
);
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    look_t              grp;
    look_t              car;
    logic               unused_fields;

    assign p = a ^ b;
    assign g = a & b;

    // PG/GG taken from a carry-independent evaluation so the segment lookahead
    // that feeds c never sees a combinational path back through this slice.
    assign grp = group_lookahead(p, g, 1'b0);
    assign car = group_lookahead(p, g, c);

    assign s  = p ^ car.c[GROUP_W-1:0];
    assign pg = grp.pg;
    assign gg = grp.gg;

    assign unused_fields = ^{grp.c, car.c[GROUP_W], car.pg, car.gg};
endmodule

// File: rtl/cla_adder_pipelined.sv
// Pipelined CLA adder/subtractor: one SEG_WIDTH segment resolved per stage,
// registered inter-segment carry, global-enable valid/ready pipeline.
module cla_adder_pipelined
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SEG_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_adder_pipelined_if.slave  bus
);
    localparam int unsigned NSEG = WIDTH / SEG_WIDTH;
    localparam int unsigned NGRP = SEG_WIDTH / GROUP_W;

    if (((WIDTH % SEG_WIDTH) != 0) || ((SEG_WIDTH % GROUP_W) != 0)) begin : g_bad_param
        $error("cla_adder_pipelined: WIDTH must be a multiple of SEG_WIDTH, SEG_WIDTH a multiple of 4");
    end

    logic advance;
    logic accept;

    assign advance      = ~g_stage[NSEG-1].v_q | bus.out_ready;
    assign accept       = bus.in_valid & advance;
    assign bus.in_ready = advance;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [WIDTH-1:0]     in_a, in_b, in_s;
        logic                 in_c, in_v;
        logic [WIDTH-1:0]     a_q, b_q, s_q;
        logic                 c_q, v_q;
        logic [SEG_WIDTH-1:0] sa, sb, ss;
        logic [NGRP-1:0]      gp, gg;
        logic [NGRP:0]        gc;

        // Stage 0 conditions operands; later stages consume the skewed registers
        if (k == 0) begin : g_first
            assign in_a = bus.a;
            assign in_b = bus.sub ? ~bus.b : bus.b;
            assign in_c = bus.sub ? 1'b1 : bus.cin;
            assign in_s = '0;
            assign in_v = accept;
        end else begin : g_next
            assign in_a = g_stage[k-1].a_q;
            assign in_b = g_stage[k-1].b_q;
            assign in_c = g_stage[k-1].c_q;
            assign in_s = g_stage[k-1].s_q;
            assign in_v = g_stage[k-1].v_q;
        end

        assign sa = in_a[SEG_WIDTH-1:0];
        assign sb = in_b[SEG_WIDTH-1:0];

        for (genvar j = 0; j < NGRP; j++) begin : g_grp
            cla_group4 u_grp (
                .a  (sa[j*GROUP_W +: GROUP_W]),
                .b  (sb[j*GROUP_W +: GROUP_W]),
                .c  (gc[j]),
                .s  (ss[j*GROUP_W +: GROUP_W]),
                .pg (gp[j]),
                .gg (gg[j])
            );
        end

        // Segment-level lookahead: each group carry as a flat sum of products
        always_comb begin
            logic prop;
            logic acc;
            gc = '0;
            for (int j = 0; j <= int'(NGRP); j++) begin
                prop = 1'b1;
                acc  = 1'b0;
                for (int i = j - 1; i >= 0; i--) begin
                    acc  = acc | (gg[i] & prop);
                    prop = prop & gp[i];
                end
                gc[j] = acc | (prop & in_c);
            end
        end

        // Operands shift down one segment; the finished segment enters the sum at the top
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= in_v;
                c_q <= gc[NGRP];
                a_q <= in_a >> SEG_WIDTH;
                b_q <= in_b >> SEG_WIDTH;
                s_q <= WIDTH'({ss, in_s} >> SEG_WIDTH);
            end
        end

        if (k == NSEG - 1) begin : g_last
            logic ovf_q;
            logic unused_skew;

            // Carry into the MSB recovered from its sum bit, compared with carry out
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= (ss[SEG_WIDTH-1] ^ sa[SEG_WIDTH-1] ^ sb[SEG_WIDTH-1]) ^ gc[NGRP];
                end
            end

            assign unused_skew = ^{a_q, b_q};
        end
    end

    assign bus.out_valid = g_stage[NSEG-1].v_q;
    assign bus.sum       = g_stage[NSEG-1].s_q;
    assign bus.cout      = g_stage[NSEG-1].c_q;
    assign bus.ovf       = g_stage[NSEG-1].g_last.ovf_q;
endmodule
